// File: rtl/ser_deframer_if.sv
`default_nettype none
// =============================================================================
// Module   : ser_deframer_if
// Brief    : Serial input, output queue handshake and error pulses of the
//            serial deframer.
// Revision : 1.0 - initial release
// =============================================================================
interface ser_deframer_if #(
    parameter int DATA_W = 16
);
    localparam int c_MOD_W = $clog2(DATA_W);

    logic               ser_data_i;
    logic               ser_data_val_i;
    logic [DATA_W-1:0]  deser_data_o;
    logic [c_MOD_W-1:0] deser_mod_o;
    logic               deser_data_val_o;
    logic               deser_ready_i;
    logic               runt_o;
    logic               overflow_o;

    modport slave (
        input  ser_data_i,
        input  ser_data_val_i,
        input  deser_ready_i,
        output deser_data_o,
        output deser_mod_o,
        output deser_data_val_o,
        output runt_o,
        output overflow_o
    );

    modport master (
        output ser_data_i,
        output ser_data_val_i,
        output deser_ready_i,
        input  deser_data_o,
        input  deser_mod_o,
        input  deser_data_val_o,
        input  runt_o,
        input  overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/ser_deframer.sv
`default_nettype none
// =============================================================================
// Module   : ser_deframer
// Brief    : Rebuilds MSB-first serial bursts into left-aligned words and
//            queues them behind a valid/ready output.
// Revision : 1.0 - initial release
// =============================================================================
module ser_deframer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  wire logic     clk_i,
    input  wire logic     arst_n_i,
    ser_deframer_if.slave bus
);
    localparam int c_CNT_W = $clog2(DATA_W + 1);
    localparam int c_MOD_W = $clog2(DATA_W);
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]  r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_q_data [DEPTH];
    logic [c_MOD_W-1:0] r_q_mod  [DEPTH];
    logic [c_OCC_W-1:0] r_occ;
    logic               r_runt;
    logic               r_overflow;

    logic               w_val;
    logic [c_CNT_W-1:0] w_pos;
    logic [DATA_W-1:0]  w_word;
    logic [c_MOD_W-1:0] w_mod;
    logic               w_close_full;
    logic               w_close_gap;
    logic               w_close;
    logic               w_runt;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_drop;
    logic [c_OCC_W-1:0] w_wr_idx;
    logic [DATA_W-1:0]  w_q_data_nxt [DEPTH];
    logic [c_MOD_W-1:0] w_q_mod_nxt  [DEPTH];

    assign w_val = bus.ser_data_val_i;

    always_comb begin
        w_pos        = c_CNT_W'(DATA_W - 1) - r_cnt;
        // The incoming bit only merges on a valid cycle; a gap closes with acc as is.
        w_word       = r_acc | ({{(DATA_W-1){1'b0}}, (w_val & bus.ser_data_i)} << w_pos);
        w_close_full = w_val && (r_cnt == c_CNT_W'(DATA_W - 1));
        w_close_gap  = !w_val && (r_cnt >= c_CNT_W'(3));
        w_close      = w_close_full || w_close_gap;
        w_runt       = !w_val && (r_cnt != '0) && (r_cnt < c_CNT_W'(3));
        w_mod        = w_close_full ? '0 : r_cnt[c_MOD_W-1:0];
        w_pop        = (r_occ != '0) && bus.deser_ready_i;
        w_push_ok    = w_close && ((r_occ != c_OCC_W'(DEPTH)) || w_pop);
        w_drop       = w_close && !w_push_ok;
        w_wr_idx     = r_occ - c_OCC_W'(w_pop);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_q_data_nxt[i] = r_q_data[i];
            w_q_mod_nxt[i]  = r_q_mod[i];
        end
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_q_data_nxt[i] = r_q_data[i+1];
                w_q_mod_nxt[i]  = r_q_mod[i+1];
            end
            w_q_data_nxt[DEPTH-1] = '0;
            w_q_mod_nxt[DEPTH-1]  = '0;
        end
        // Write slot accounts for the shift, so a push on a pop lands behind the survivors.
        if (w_push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (c_OCC_W'(i) == w_wr_idx) begin
                    w_q_data_nxt[i] = w_word;
                    w_q_mod_nxt[i]  = w_mod;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_occ      <= '0;
            r_runt     <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_mod[i]  <= '0;
            end
        end else begin
            r_runt     <= w_runt;
            r_overflow <= w_drop;
            if (w_close || !w_val) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_word;
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= w_q_data_nxt[i];
                r_q_mod[i]  <= w_q_mod_nxt[i];
            end
            r_occ <= r_occ + c_OCC_W'(w_push_ok) - c_OCC_W'(w_pop);
        end
    end

    assign bus.deser_data_val_o = (r_occ != '0);
    assign bus.deser_data_o     = (r_occ != '0) ? r_q_data[0] : '0;
    assign bus.deser_mod_o      = (r_occ != '0) ? r_q_mod[0]  : '0;
    assign bus.runt_o           = r_runt;
    assign bus.overflow_o       = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_ser_deframer.sv
`default_nettype none
// =============================================================================
// Module   : tb_ser_deframer
// Brief    : Directed and randomized bench for ser_deframer against a
//            burst/queue-level reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ser_deframer;
    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  m;
    } word_t;

    logic clk_i = 1'b0;
    logic arst_n_i;
    always #5 clk_i = ~clk_i;

    ser_deframer_if #(.DATA_W(16)) bus ();

    ser_deframer #(.DATA_W(16), .DEPTH(2)) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .bus      (bus)
    );

    // Reference model: bits of the burst in progress and the output FIFO.
    bit    mb[$];
    word_t mq[$];
    bit    m_runt;
    bit    m_ovf;
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: observed %0h expected %0h (t=%0t)", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic word_t pack_burst();
        word_t w;
        w.d = '0;
        foreach (mb[i]) w.d[15-i] = mb[i];
        w.m = 4'(mb.size());
        return w;
    endfunction

    task automatic model_edge(input bit v, input bit b, input bit r);
        bit    pop;
        bit    closed;
        word_t w;
        pop    = (mq.size() != 0) && r;
        closed = 1'b0;
        w      = '0;
        m_runt = 1'b0;
        m_ovf  = 1'b0;
        if (v) begin
            mb.push_back(b);
            if (mb.size() == 16) begin
                w = pack_burst();
                closed = 1'b1;
                mb.delete();
            end
        end else begin
            if (mb.size() >= 3) begin
                w = pack_burst();
                closed = 1'b1;
            end else if (mb.size() > 0) begin
                m_runt = 1'b1;
            end
            mb.delete();
        end
        if (pop) void'(mq.pop_front());
        if (closed) begin
            if (mq.size() < 2) mq.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("val",  32'(bus.deser_data_val_o), 32'(mq.size() != 0));
        check("data", 32'(bus.deser_data_o), (mq.size() != 0) ? 32'(mq[0].d) : 32'd0);
        check("mod",  32'(bus.deser_mod_o),  (mq.size() != 0) ? 32'(mq[0].m) : 32'd0);
        check("runt", 32'(bus.runt_o),     32'(m_runt));
        check("ovf",  32'(bus.overflow_o), 32'(m_ovf));
    endtask

    task automatic check_zero();
        check("rst_val",  32'(bus.deser_data_val_o), 32'd0);
        check("rst_data", 32'(bus.deser_data_o),     32'd0);
        check("rst_mod",  32'(bus.deser_mod_o),      32'd0);
        check("rst_runt", 32'(bus.runt_o),           32'd0);
        check("rst_ovf",  32'(bus.overflow_o),       32'd0);
    endtask

    task automatic step(input bit v, input bit b, input bit r);
        bus.ser_data_val_i = v;
        bus.ser_data_i     = b;
        bus.deser_ready_i  = r;
        @(posedge clk_i);
        #1;
        model_edge(v, b, r);
        check_outputs();
    endtask

    task automatic send_bits(input logic [31:0] pat, input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b1, pat[n-1-i], r);
    endtask

    // Called shortly after a rising edge, so the reset lands mid-cycle.
    task automatic async_reset();
        #3;
        arst_n_i = 1'b0;
        #1;
        check_zero();
        mb.delete();
        mq.delete();
        m_runt = 1'b0;
        m_ovf  = 1'b0;
        bus.ser_data_val_i = 1'b0;
        bus.ser_data_i     = 1'b0;
        bus.deser_ready_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #4;
        arst_n_i = 1'b1;
    endtask

    initial begin
        word_t held;
        arst_n_i           = 1'b0;
        bus.ser_data_val_i = 1'b0;
        bus.ser_data_i     = 1'b0;
        bus.deser_ready_i  = 1'b0;
        m_runt = 1'b0;
        m_ovf  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        phase = "reset";
        check_zero();
        #3;
        arst_n_i = 1'b1;
        step(1'b0, 1'b0, 1'b1);

        phase = "full16";
        send_bits(32'hA5C3, 16, 1'b1);
        check("word", 32'(bus.deser_data_o), 32'hA5C3);
        check("mod0", 32'(bus.deser_mod_o), 32'd0);
        check("vld",  32'(bus.deser_data_val_o), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        check("norunt", 32'(bus.runt_o), 32'd0);

        phase = "gap5";
        send_bits(32'b10111, 5, 1'b1);
        check("notyet", 32'(bus.deser_data_val_o), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("word", 32'(bus.deser_data_o), 32'hB800);
        check("mod5", 32'(bus.deser_mod_o), 32'd5);
        step(1'b0, 1'b0, 1'b1);

        phase = "runt2";
        send_bits(32'b11, 2, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("pulse", 32'(bus.runt_o), 32'd1);
        check("noq",   32'(bus.deser_data_val_o), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("once",  32'(bus.runt_o), 32'd0);

        phase = "runt1";
        send_bits(32'b1, 1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("pulse", 32'(bus.runt_o), 32'd1);
        step(1'b0, 1'b0, 1'b1);

        phase = "split20";
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (i == 15) begin
                check("w1", 32'(bus.deser_data_o), 32'hFFFF);
                check("m1", 32'(bus.deser_mod_o), 32'd0);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        check("w2", 32'(bus.deser_data_o), 32'hF000);
        check("m2", 32'(bus.deser_mod_o), 32'd4);
        step(1'b0, 1'b0, 1'b1);

        phase = "overflow";
        send_bits(32'b101, 3, 1'b0); step(1'b0, 1'b0, 1'b0);
        send_bits(32'b011, 3, 1'b0); step(1'b0, 1'b0, 1'b0);
        send_bits(32'b110, 3, 1'b0); step(1'b0, 1'b0, 1'b0);
        check("pulse", 32'(bus.overflow_o), 32'd1);
        check("head",  32'(bus.deser_data_o), 32'hA000);
        held = '{d: bus.deser_data_o, m: bus.deser_mod_o};
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("once",   32'(bus.overflow_o), 32'd0);
        check("stable", 32'(bus.deser_data_o), 32'(held.d));
        step(1'b0, 1'b0, 1'b1);
        check("drain2", 32'(bus.deser_data_o), 32'h6000);
        check("drmod",  32'(bus.deser_mod_o), 32'd3);
        step(1'b0, 1'b0, 1'b1);
        check("empty",  32'(bus.deser_data_val_o), 32'd0);

        phase = "popfull";
        send_bits(32'b101, 3, 1'b0); step(1'b0, 1'b0, 1'b0);
        send_bits(32'b011, 3, 1'b0); step(1'b0, 1'b0, 1'b0);
        send_bits(32'b110, 3, 1'b0); step(1'b0, 1'b0, 1'b1);
        check("noovf", 32'(bus.overflow_o), 32'd0);
        check("head",  32'(bus.deser_data_o), 32'h6000);
        step(1'b0, 1'b0, 1'b1);
        check("third", 32'(bus.deser_data_o), 32'hC000);
        check("vld",   32'(bus.deser_data_val_o), 32'd1);
        step(1'b0, 1'b0, 1'b1);

        phase = "midreset";
        send_bits(32'h5B, 7, 1'b1);
        async_reset();
        send_bits(32'h1234, 16, 1'b1);
        check("word", 32'(bus.deser_data_o), 32'h1234);
        check("mod0", 32'(bus.deser_mod_o), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("norunt", 32'(bus.runt_o), 32'd0);

        phase = "random";
        for (int k = 0; k < 400; k++) begin
            int len;
            int bias;
            len  = int'($urandom_range(1, 24));
            bias = int'($urandom_range(0, 3));
            for (int i = 0; i < len; i++)
                step(1'b1, 1'($urandom), ($urandom_range(0, 3) < 32'(bias)));
            repeat ($urandom_range(1, 3))
                step(1'b0, 1'($urandom), ($urandom_range(0, 3) < 32'(bias)));
            if (k == 200) begin
                send_bits(32'($urandom), int'($urandom_range(1, 12)), 1'b0);
                async_reset();
            end
        end
        repeat (4) step(1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
